// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths and write-back counter width
package regfile_pkg;
  localparam int DEF_BUS_WIDTH   = 64;
  localparam int DEF_REGFILE_LEN = 6;
  localparam int WB_CNT_W        = 16;
  typedef logic [WB_CNT_W-1:0] wb_cnt_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant starting the search at ptr
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] k;
  // scan offsets from farthest to nearest so the requester closest to ptr wins last
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    k = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % NUM_REQ);
      if (req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        gnt_idx = k;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter into a register file; WB_ARB_X0_DROP_EN suppresses writes to address 0
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int REGFILE_LEN = DEF_REGFILE_LEN,
  parameter int NUM_REQ     = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*REGFILE_LEN-1:0] req_addr,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
  output logic                           rf_write_enable,
  output logic [REGFILE_LEN-1:0]         rf_write_addr,
  output logic [BUS_WIDTH-1:0]           rf_write_data,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic [WB_CNT_W-1:0]            wb_count
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]     gnt;
  logic [IW-1:0]          gnt_idx, rr_ptr_q, rr_ptr_d, gid_q, gid_d;
  logic                   we_q, we_d;
  logic [REGFILE_LEN-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0]   data_q, data_d;
  wb_cnt_t                cnt_q, cnt_d;
  logic [REGFILE_LEN-1:0] addr_a [NUM_REQ];
  logic [BUS_WIDTH-1:0]   data_a [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_a[g] = req_addr[g*REGFILE_LEN +: REGFILE_LEN];
    assign data_a[g] = req_data[g*BUS_WIDTH +: BUS_WIDTH];
  end
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );
  assign req_ready       = rst_n ? gnt : '0;
  assign rf_write_enable = we_q;
  assign rf_write_addr   = addr_q;
  assign rf_write_data   = data_q;
  assign grant_id        = gid_q;
  assign wb_count        = cnt_q;
  // capture the granted write, advance the pointer past the winner, count issued writes
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    gid_d = gid_q;
    if (|gnt) begin
      rr_ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      addr_d = addr_a[gnt_idx];
      data_d = data_a[gnt_idx];
      gid_d = gnt_idx;
`ifdef WB_ARB_X0_DROP_EN
      we_d = |addr_a[gnt_idx];
`else
      we_d = 1'b1;
`endif
    end
    cnt_d = (we_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  // state registers, cleared asynchronously so in-flight writes are discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      gid_q <= '0;
      cnt_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      gid_q <= gid_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
